// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, frame
// constants and the per-state output decode used by the loader FSM.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_t;

    typedef struct packed {
        logic s_ready;
        logic busy;
        logic done;
        logic err;
        logic cpu_rst_n;
    } loader_flags_t;

    // Status outputs are registered together with the state, so they are
    // loaded from the decode of the state being entered.
    function automatic loader_flags_t flags_for(loader_state_t s);
        loader_flags_t f;
        f = '0;
        case (s)
            ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: begin
                f.s_ready = 1'b1;
                f.busy    = 1'b1;
            end
            ST_DONE: begin
                f.done      = 1'b1;
                f.cpu_rst_n = 1'b1;
            end
            ST_ERR:  f.err = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles little-endian 32-bit words from an accepted byte stream and
// emits a one-cycle word_valid pulse the cycle after the fourth byte.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
            end else if (byte_valid) begin
                // Shifting in from the top leaves byte 0 in bits [7:0]
                // once all four lanes have been filled.
                word       <= {byte_data, word[31:8]};
                lane       <= lane + 2'd1;
                word_valid <= (lane == LAST_LANE);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into instruction
// memory and holds the CPU in reset until a good frame has been loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Stream handshake: a byte moves on a rising edge where s_valid and
    // s_ready are both 1; s_ready is high only in LEN0, LEN1, DATA and CSUM.

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    loader_state_t state;
    loader_flags_t flags;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [15:0]   word_cnt;
    logic [7:0]    csum;
    logic [ADDR_W-1:0] addr;

    logic        byte_fire;
    logic        data_fire;
    logic        load_start;
    logic [15:0] len_full;
    logic [1:0]  lane;
    logic [31:0] pk_word;
    logic        pk_valid;

    assign byte_fire  = s_valid && flags.s_ready;
    assign data_fire  = byte_fire && (state == ST_DATA);
    assign load_start = start && !flags.busy;
    assign len_full   = {s_data, len_lo};

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start),
        .byte_valid (data_fire),
        .byte_data  (s_data),
        .lane       (lane),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign s_ready    = flags.s_ready;
    assign busy       = flags.busy;
    assign done       = flags.done;
    assign err        = flags.err;
    assign cpu_rst_n  = flags.cpu_rst_n;
    assign imem_we    = pk_valid;
    assign imem_wdata = pk_word;
    assign imem_addr  = addr;
    assign dbg_state  = state;

    // Word address follows the write strobe, so it points at the word
    // being written during the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load_start) begin
            addr <= '0;
        end else if (pk_valid) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            flags    <= '0;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            word_cnt <= 16'd0;
            csum     <= 8'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_LEN0;
                        flags    <= flags_for(ST_LEN0);
                        len_lo   <= 8'd0;
                        len      <= 16'd0;
                        word_cnt <= 16'd0;
                        csum     <= 8'd0;
                    end
                end
                ST_LEN0: begin
                    if (byte_fire) begin
                        len_lo <= s_data;
                        state  <= ST_LEN1;
                        flags  <= flags_for(ST_LEN1);
                    end
                end
                ST_LEN1: begin
                    if (byte_fire) begin
                        len <= len_full;
                        if ({1'b0, len_full} > DEPTH_LIM) begin
                            state <= ST_ERR;
                            flags <= flags_for(ST_ERR);
                        end else if (len_full == 16'd0) begin
                            state <= ST_CSUM;
                            flags <= flags_for(ST_CSUM);
                        end else begin
                            state <= ST_DATA;
                            flags <= flags_for(ST_DATA);
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_fire) begin
                        csum <= csum ^ s_data;
                        if (lane == 2'd3) begin
                            word_cnt <= word_cnt + 16'd1;
                            if (word_cnt == len - 16'd1) begin
                                state <= ST_CSUM;
                                flags <= flags_for(ST_CSUM);
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (byte_fire) begin
                        if (s_data == csum) begin
                            state <= ST_DONE;
                            flags <= flags_for(ST_DONE);
                        end else begin
                            state <= ST_ERR;
                            flags <= flags_for(ST_ERR);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    flags <= flags_for(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames against a frame-level
// reference model of expected imem writes and final status.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int W     = AW + 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];
    logic [31:0]   frame_words[$];

    int n_checks = 0;
    int n_fail   = 0;
    int gap_pct  = 0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // Capture every imem write mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && imem_we) got_q.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit accepted;
        int guard;
        while ($urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = b;
        guard   = 0;
        forever begin
            accepted = s_ready;
            tick();
            if (accepted) break;
            guard++;
            if (guard > 100) begin
                check("byte_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Reference: a frame of n words is accepted only if n fits in memory;
    // every word lands at its index, and success needs the XOR of all data
    // bytes to match the trailing checksum byte.
    task automatic run_frame(input string tag, input int n, input bit bad_csum);
        logic [7:0]  csum;
        logic [31:0] w;
        bit          len_ok;
        bit          exp_ok;
        exp_q.delete();
        got_q.delete();
        csum = 8'd0;
        foreach (frame_words[i])
            for (int k = 0; k < 4; k++) csum ^= frame_words[i][8*k +: 8];
        len_ok = (n <= DEPTH);
        exp_ok = len_ok && !bad_csum;

        pulse_start();
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_cpu_held_after_start"}, cpu_rst_n, 0);

        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (len_ok) begin
            for (int i = 0; i < n; i++) begin
                w = frame_words[i];
                for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
                exp_q.push_back({AW'(i), w});
            end
            send_byte(bad_csum ? (csum ^ 8'h01) : csum);
        end
        repeat (3) tick();

        check({tag, "_write_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_done"}, done, exp_ok);
        check({tag, "_err"}, err, !exp_ok);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, exp_ok);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("idle_no_busy", busy, 0);

        frame_words = '{32'h04000013, 32'h00800007};
        run_frame("basic", 2, 1'b0);
        run_frame("bad_csum", 2, 1'b1);
        frame_words.delete();
        run_frame("too_long", 1025, 1'b0);
        run_frame("empty", 0, 1'b0);

        frame_words = '{32'h04000013, 32'h00800007};
        gap_pct = 40;
        run_frame("gaps", 2, 1'b0);

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 6);
            frame_words.delete();
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            gap_pct = $urandom_range(0, 50);
            bad = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", t), n, bad);
        end
        gap_pct = 0;

        // Abort after five data bytes: only word 0 may reach imem.
        got_q.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h07);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midload_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("midload_write_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("midload_write0", got_q[0], {AW'(0), 32'h04000013});
        check("midload_busy", busy, 0);

        frame_words = '{32'hDEADBEEF};
        run_frame("one_word", 1, 1'b0);
        frame_words = '{32'h12345678};
        run_frame("restart", 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 The module SHALL have localparam ADDR_W, value $clog2(DEPTH), meaning the imem word-address width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 s_valid  input  1  byte-stream valid.
REQ-007 s_data  input  8  byte-stream data.
REQ-008 s_ready  output  1  byte-stream ready; a byte transfers on a cycle with s_valid=1 and s_ready=1.
REQ-009 imem_we  output  1  imem write strobe; connects to the CPU tb_imem_we.
REQ-010 imem_addr  output  ADDR_W  imem word address; connects to tb_imem_addr.
REQ-011 imem_wdata  output  32  imem write data; connects to tb_imem_wdata.
REQ-012 cpu_rst_n  output  1  active-low hold for the CPU core.
REQ-013 busy  output  1  a load is in progress.
REQ-014 done  output  1  the load completed with a good checksum.
REQ-015 err  output  1  the load failed (length or checksum).

Function
REQ-016 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, CSUM, DONE and ERR.
REQ-017 Frame format SHALL be: N[7:0], N[15:8], then N*4 data bytes with each word little-endian, then 1 checksum byte.
REQ-018 IDLE, DONE and ERR SHALL move to LEN0 on start=1; start SHALL be ignored in LEN0, LEN1, DATA and CSUM.
REQ-019 s_ready SHALL be 1 exactly in LEN0, LEN1, DATA and CSUM.
REQ-020 busy SHALL be 1 exactly in LEN0, LEN1, DATA and CSUM.
REQ-021 LEN0 SHALL capture the low byte of N and LEN1 the high byte.
REQ-022 From LEN1, the FSM SHALL go to ERR if N>DEPTH, to CSUM if N==0, and to DATA otherwise.
REQ-023 In DATA, a 2-bit byte-lane counter SHALL place each accepted byte into word bits [8*lane+7:8*lane].
REQ-024 On acceptance of lane 3, the next cycle SHALL drive imem_we=1 for exactly one cycle, with imem_addr=word index and imem_wdata=the assembled word.
REQ-025 Word indices SHALL start at 0 and increment by 1 per written word.
REQ-026 After word N-1 has been accepted, the FSM SHALL go to CSUM.
REQ-027 The running checksum SHALL be the XOR of all data bytes only, excluding the length bytes, and SHALL be cleared on entry to LEN0.
REQ-028 In CSUM, if the accepted byte equals the running checksum the FSM SHALL go to DONE, otherwise to ERR.
REQ-029 The final imem write SHALL complete before or in the same cycle as entry to DONE.
REQ-030 done SHALL be 1 only in DONE, and err SHALL be 1 only in ERR.
REQ-031 cpu_rst_n SHALL be 1 only in DONE, so the CPU is held in reset in IDLE, while loading and in ERR.
REQ-032 A restart from DONE SHALL drop cpu_rst_n on the cycle after start.
REQ-033 Stalls (s_valid=0) SHALL NOT change any state, counter or checksum.
REQ-034 imem_we SHALL be 0 in every state except during the strobe cycle of REQ-024.

Reset
REQ-035 On rst_n=0, the FSM SHALL go to IDLE and set s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0 and err=0.
REQ-036 On rst_n=0, counters and checksum SHALL clear.
REQ-037 Reset asserted mid-load SHALL abort the load with no further imem writes; words already written SHALL remain in imem.

Structure
REQ-038 The FSM state enum and the frame constants (LEN_BYTES=2, WORD_BYTES=4) SHALL live in a shared loader package alongside the ISA definitions package.
REQ-039 One sub-module SHALL be used: byte_to_word_packer, containing the lane counter, the 32-bit shift register and the word-valid pulse.
REQ-040 The top of imem_loader SHALL contain the FSM, the word-address counter and the checksum.

Verification
REQ-041 Load bytes 02 00 | 13 00 00 04 | 07 00 80 00 | csum=13^04^07^80=0x90 -> imem[0]=0x04000013, imem[1]=0x00800007, done=1, cpu_rst_n rises, err=0.
REQ-042 Same frame with csum byte 0x91 -> both words are written, the FSM ends in ERR with err=1 and cpu_rst_n=0.
REQ-043 With DEPTH=1024, send length 01 04 (N=1025) -> ERR immediately after LEN1, no imem_we pulses, s_ready=0.
REQ-044 Send 00 00 00 (N=0, csum=0) -> DONE, zero writes.
REQ-045 Insert random s_valid gaps within the REQ-041 frame -> identical writes and identical final state; assert rst_n=0 after 5 data bytes -> only imem[0] is written, all outputs at reset values.
REQ-046 In DONE, pulse start and send a new 1-word frame -> cpu_rst_n=0 on the next cycle, the new word is at imem[0], and the FSM returns to DONE.
